lm71_temp_reader: RTL
=====================

Name: lm71_temp_reader

Overview:
- Serial master for the on-board LM71CIMF temperature sensor.
- Sits directly behind the sensor pins (cs_n, sc, sio) and supplies the temperature register to the system-side logic.
- Each transaction does a 16-bit read and then a 16-bit mode write on a shared bidirectional SIO line.
- Transactions start from a free-running poll timer or from a manual start pulse. Output is a signed 14-bit temperature with a one-cycle valid strobe.

Parameters:
- CLK_DIV, 8: clk cycles per SC half-period; with a 50 MHz clk, SC = 3.125 MHz. Legal range 2..255.
- POLL_CYCLES, 12500000: clk cycles between automatic transactions (250 ms at 50 MHz). Minimum 1024.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = poll timer runs and triggers transactions
- start  in  1  one-cycle pulse; triggers a transaction immediately if idle
- shutdown  in  1  mode select; sampled at transaction start: 1 writes 0xFFFF (shutdown), 0 writes 0x0000 (continuous conversion)
- temp_data  out  14  signed two's complement temperature, LSB = 0.03125 degC
- temp_valid  out  1  one-cycle pulse when temp_data and id_ok update
- id_ok  out  1  1 when the received bits [1:0] equal 2'b11
- busy  out  1  high from the trigger cycle through the DONE cycle
- cs_n  out  1  sensor chip select, active low
- sc  out  1  sensor serial clock
- sio  inout  1  sensor serial data; driven only during the WRITE phase, high-Z otherwise

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: cs_n=1, sc=0, sio high-Z, temp_data=0, temp_valid=0, id_ok=0, busy=0, poll counter=0, FSM=IDLE.
- Reset asserted mid-transaction forces all of these values on the next clk edge. No partial data is published.
- FSM states: IDLE, SETUP, READ, WRITE, HOLD, DONE.
- IDLE: a trigger moves the FSM to SETUP. Triggers are a start pulse, or the poll counter reaching POLL_CYCLES-1 while enable=1.
  - On the trigger cycle: busy goes 1 and shutdown is latched.
  - On the next edge: cs_n goes 0.
- Poll counter: increments only in IDLE with enable=1. It clears on a trigger and when enable=0.
- start while busy=1 is ignored and not queued. start and the poll expiry in the same cycle produce one transaction.
- SETUP: CLK_DIV cycles with cs_n=0 and sc=0, then go to READ.
- Bit timing (READ and WRITE): each bit is CLK_DIV cycles with sc=0, then CLK_DIV cycles with sc=1. Bits are MSB first.
- READ: 16 bits, sio high-Z. sio is sampled into a 16-bit shift register on the clk edge where sc transitions 0->1.
- WRITE: 16 bits of the mode word, all ones if the latched shutdown is 1, else all zeros.
  - sio output enable asserts at the first sc-low phase of WRITE.
  - Data changes only when sc transitions 1->0 or at WRITE entry.
  - The output enable releases on the edge leaving WRITE.
- HOLD: sc=0, cs_n=0 for CLK_DIV cycles. Then cs_n=1 and go to DONE.
- DONE (1 cycle): temp_data=rx[15:2], id_ok=(rx[1:0]==2'b11), temp_valid=1 for this cycle only. Then IDLE with busy=0.
- temp_data is published even when id_ok=0.
- Transaction length: trigger to temp_valid = 1 + CLK_DIV + 64*CLK_DIV + CLK_DIV + 1 cycles, which is 530 cycles for CLK_DIV=8.
- cs_n stays high for at least 1 cycle between back-to-back start-triggered transactions.
- enable deasserted mid-transaction: the transaction completes normally.
- temp_data and id_ok hold their values between transactions.
- sc never toggles while cs_n=1.
- Half-period counter width is ceil(log2(CLK_DIV)). The poll counter is ceil(log2(POLL_CYCLES)) bits and is reset to 0 on each wrap.

Test Plan:
- Sensor model returns 0x0C83, start pulse, CLK_DIV=8 -> temp_valid after 530 cycles, temp_data=800 (25.0 degC), id_ok=1, exactly 16 rising sc edges read plus 16 write.
- Model returns 0xEC03 -> temp_data=14'h3B00 (-1280, -40.0 degC), id_ok=1. Model returns 0x0C80 -> temp_data=800, id_ok=0.
- shutdown=1 at start -> sensor model captures write word 0xFFFF. shutdown=0 -> 0x0000. sio high-Z during SETUP, READ and HOLD.
- start pulsed at 5 and 200 cycles after the first trigger -> only one transaction; busy stays 1; the second start produces no extra cs_n pulse.
- POLL_CYCLES=1024, enable=1, no start -> successive cs_n falling edges 1024+530 cycles apart. enable=0 -> no transactions and counter held at 0.
- reset asserted at cycle 300 of a transaction -> next edge gives cs_n=1, sc=0, sio high-Z, busy=0, temp_data=0, no temp_valid. A subsequent start works normally.

Source files
------------

// File: rtl/lm71_temp_reader_if.sv
// ============================================================================
// Module      : lm71_temp_reader_if
// Description : System-side control/status bundle for the LM71 temperature reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lm71_temp_reader_if;
    logic        enable;
    logic        start;
    logic        shutdown;
    logic [13:0] temp_data;
    logic        temp_valid;
    logic        id_ok;
    logic        busy;

    modport master (
        output enable, start, shutdown,
        input  temp_data, temp_valid, id_ok, busy
    );

    modport slave (
        input  enable, start, shutdown,
        output temp_data, temp_valid, id_ok, busy
    );
endinterface

`default_nettype wire

// File: rtl/lm71_temp_reader.sv
// ============================================================================
// Module      : lm71_temp_reader
// Description : LM71 serial master: 16-bit temperature read, then 16-bit mode write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lm71_temp_reader #(
    parameter int CLK_DIV     = 8,
    parameter int POLL_CYCLES = 12500000
) (
    input  wire                   clk,
    input  wire                   reset,
    lm71_temp_reader_if.slave     ctl,
    output logic                  cs_n,
    output logic                  sc,
    inout  wire                   sio
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int POLL_W = $clog2(POLL_CYCLES);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        HOLD  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [3:0]         bit_cnt;
    logic [POLL_W-1:0]  poll_cnt;
    logic [15:0]        rx_shift;
    logic               mode_bit;
    logic               sio_oe;
    logic               sio_out;
    logic [13:0]        temp_data;
    logic               temp_valid;
    logic               id_ok;
    logic               busy;

    logic               poll_hit;
    logic               trigger;
    logic               half_done;

    assign poll_hit  = ctl.enable && (poll_cnt == POLL_LAST);
    assign trigger   = (state == IDLE) && (ctl.start || poll_hit);
    assign half_done = (div_cnt == DIV_LAST);

    assign sio = sio_oe ? sio_out : 1'bz;

    assign ctl.temp_data  = temp_data;
    assign ctl.temp_valid = temp_valid;
    assign ctl.id_ok      = id_ok;
    assign ctl.busy       = busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            poll_cnt   <= '0;
            rx_shift   <= '0;
            mode_bit   <= 1'b0;
            cs_n       <= 1'b1;
            sc         <= 1'b0;
            sio_oe     <= 1'b0;
            sio_out    <= 1'b0;
            temp_data  <= '0;
            temp_valid <= 1'b0;
            id_ok      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            temp_valid <= 1'b0;

            if (!ctl.enable || trigger)
                poll_cnt <= '0;
            else if (state == IDLE)
                poll_cnt <= poll_cnt + POLL_W'(1);

            case (state)
                IDLE: begin
                    if (trigger) begin
                        state    <= SETUP;
                        busy     <= 1'b1;
                        mode_bit <= ctl.shutdown;
                        div_cnt  <= '0;
                    end
                end

                // First SETUP cycle only drops cs_n; the CLK_DIV setup window follows.
                SETUP: begin
                    if (cs_n) begin
                        cs_n <= 1'b0;
                    end else if (half_done) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= READ;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                READ: begin
                    if (half_done) begin
                        div_cnt <= '0;
                        if (!sc) begin
                            sc       <= 1'b1;
                            rx_shift <= {rx_shift[14:0], sio};
                        end else begin
                            sc <= 1'b0;
                            if (bit_cnt == 4'd15) begin
                                bit_cnt <= '0;
                                state   <= WRITE;
                                sio_oe  <= 1'b1;
                                sio_out <= mode_bit;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                WRITE: begin
                    if (half_done) begin
                        div_cnt <= '0;
                        if (!sc) begin
                            sc <= 1'b1;
                        end else begin
                            sc <= 1'b0;
                            if (bit_cnt == 4'd15) begin
                                bit_cnt <= '0;
                                state   <= HOLD;
                                sio_oe  <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                                sio_out <= mode_bit;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                HOLD: begin
                    if (half_done) begin
                        div_cnt    <= '0;
                        cs_n       <= 1'b1;
                        state      <= DONE;
                        temp_data  <= rx_shift[15:2];
                        id_ok      <= (rx_shift[1:0] == 2'b11);
                        temp_valid <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
